// File: rtl/glyph_pkg.sv
// rtl/glyph_pkg.sv - shared defaults, glyph codes and FSM encoding for the glyph blitter
package glyph_pkg;

    localparam int DEFAULT_GLYPH_W    = 8;
    localparam int DEFAULT_GLYPH_H    = 10;
    localparam int DEFAULT_NUM_GLYPHS = 64;
    localparam int DEFAULT_COORD_W    = 8;
    localparam int DEFAULT_COLOUR_W   = 6;
    localparam int DEFAULT_MAX_SCALE  = 4;
    localparam int DEFAULT_CODE_W     = $clog2(DEFAULT_NUM_GLYPHS);
    localparam int DEFAULT_SCALE_W    = $clog2(DEFAULT_MAX_SCALE + 1);

    localparam logic [DEFAULT_CODE_W-1:0] GLYPH_I = 6'd8;
    localparam logic [DEFAULT_CODE_W-1:0] GLYPH_L = 6'd11;
    localparam logic [DEFAULT_CODE_W-1:0] GLYPH_T = 6'd19;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EMIT  = 2'd2,
        DONE  = 2'd3
    } blit_state_e;

endpackage

// File: rtl/glyph_blitter_if.sv
// rtl/glyph_blitter_if.sv - request and plot-stream bundle between a client and the glyph blitter
interface glyph_blitter_if #(
    parameter int CODE_W   = glyph_pkg::DEFAULT_CODE_W,
    parameter int COORD_W  = glyph_pkg::DEFAULT_COORD_W,
    parameter int COLOUR_W = glyph_pkg::DEFAULT_COLOUR_W,
    parameter int SCALE_W  = glyph_pkg::DEFAULT_SCALE_W
);
    logic                start;
    logic                start_ready;
    logic [CODE_W-1:0]   code;
    logic [COORD_W-1:0]  origin_x;
    logic [COORD_W-1:0]  origin_y;
    logic [COLOUR_W-1:0] fg_colour;
    logic [COLOUR_W-1:0] bg_colour;
    logic                opaque;
    logic [SCALE_W-1:0]  scale;
    logic                plot_valid;
    logic                plot_ready;
    logic [COORD_W-1:0]  plot_x;
    logic [COORD_W-1:0]  plot_y;
    logic [COLOUR_W-1:0] plot_colour;
    logic                done;

    modport master (
        output start, code, origin_x, origin_y, fg_colour, bg_colour, opaque, scale, plot_ready,
        input  start_ready, plot_valid, plot_x, plot_y, plot_colour, done
    );

    modport slave (
        input  start, code, origin_x, origin_y, fg_colour, bg_colour, opaque, scale, plot_ready,
        output start_ready, plot_valid, plot_x, plot_y, plot_colour, done
    );
endinterface

// File: rtl/glyph_rom.sv
// rtl/glyph_rom.sv - synchronous glyph bitmap ROM, one row per read, address = {code, row}
module glyph_rom
    import glyph_pkg::*;
#(
    parameter int GLYPH_W = DEFAULT_GLYPH_W,
    parameter int GLYPH_H = DEFAULT_GLYPH_H,
    parameter int CODE_W  = DEFAULT_CODE_W,
    parameter int ROW_W   = $clog2(GLYPH_H)
)(
    input  logic                     clk,
    input  logic [CODE_W+ROW_W-1:0]  addr,
    output logic [GLYPH_W-1:0]       row
);

    // MSB of each row is the leftmost pixel; undefined codes read as blank.
    function automatic logic [GLYPH_W-1:0] row_of(input logic [CODE_W-1:0] c,
                                                  input logic [ROW_W-1:0]  r);
        logic [7:0] bits;
        bits = 8'h00;
        if (r <= ROW_W'(GLYPH_H - 1)) begin
            case (c)
                CODE_W'(GLYPH_I): bits = (r == '0 || r == ROW_W'(GLYPH_H - 1)) ? 8'b0111_1100 : 8'b0001_0000;
                CODE_W'(GLYPH_L): bits = (r == ROW_W'(GLYPH_H - 1)) ? 8'b0001_1111 : 8'b0001_0000;
                CODE_W'(GLYPH_T): bits = (r == '0) ? 8'b1111_1110 : 8'b0001_0000;
                default:          bits = 8'h00;
            endcase
        end
        return GLYPH_W'(bits);
    endfunction

    always_ff @(posedge clk) begin
        row <= row_of(addr[CODE_W+ROW_W-1:ROW_W], addr[ROW_W-1:0]);
    end

endmodule

// File: rtl/glyph_blitter.sv
// rtl/glyph_blitter.sv - walks one glyph bitmap and streams scaled (x, y, colour) plot writes
module glyph_blitter
    import glyph_pkg::*;
#(
    parameter int GLYPH_W    = DEFAULT_GLYPH_W,
    parameter int GLYPH_H    = DEFAULT_GLYPH_H,
    parameter int NUM_GLYPHS = DEFAULT_NUM_GLYPHS,
    parameter int COORD_W    = DEFAULT_COORD_W,
    parameter int COLOUR_W   = DEFAULT_COLOUR_W,
    parameter int MAX_SCALE  = DEFAULT_MAX_SCALE
)(
    input  logic            clk,
    input  logic            reset,
    glyph_blitter_if.slave  bus
);

    localparam int CODE_W  = $clog2(NUM_GLYPHS);
    localparam int SCALE_W = $clog2(MAX_SCALE + 1);
    localparam int ROW_W   = $clog2(GLYPH_H);
    localparam int GX_W    = $clog2(GLYPH_W);

    localparam logic [GX_W-1:0]  GX_LAST = GX_W'(GLYPH_W - 1);
    localparam logic [ROW_W-1:0] GY_LAST = ROW_W'(GLYPH_H - 1);

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_FETCH = FETCH;
    localparam logic [1:0] S_EMIT  = EMIT;
    localparam logic [1:0] S_DONE  = DONE;

    logic [1:0]          state;
    logic [CODE_W-1:0]   code_q;
    logic [COORD_W-1:0]  origin_x_q;
    logic [COLOUR_W-1:0] fg_q;
    logic [COLOUR_W-1:0] bg_q;
    logic                opaque_q;
    logic [SCALE_W-1:0]  scale_last;
    logic [SCALE_W-1:0]  sx;
    logic [SCALE_W-1:0]  sy;
    logic [GX_W-1:0]     gx;
    logic [ROW_W-1:0]    gy;
    logic [COORD_W-1:0]  cur_x;
    logic [COORD_W-1:0]  cur_y;
    logic                last_q;

    logic                plot_valid_q;
    logic [COORD_W-1:0]  plot_x_q;
    logic [COORD_W-1:0]  plot_y_q;
    logic [COLOUR_W-1:0] plot_colour_q;

    logic [GLYPH_W-1:0]  row_bits;
    logic [SCALE_W-1:0]  scale_eff;
    logic [GX_W-1:0]     bit_idx;
    logic                pixel_lit;
    logic                advance;

    glyph_rom #(
        .GLYPH_W (GLYPH_W),
        .GLYPH_H (GLYPH_H),
        .CODE_W  (CODE_W),
        .ROW_W   (ROW_W)
    ) u_rom (
        .clk  (clk),
        .addr ({code_q, gy}),
        .row  (row_bits)
    );

    always_comb begin
        scale_eff = bus.scale;
        if (bus.scale == '0)
            scale_eff = SCALE_W'(1);
        else if (bus.scale > SCALE_W'(MAX_SCALE))
            scale_eff = SCALE_W'(MAX_SCALE);
    end

    assign bit_idx   = GX_LAST - gx;
    assign pixel_lit = row_bits[bit_idx];
    // The output register is free when empty or being drained this cycle.
    assign advance   = !plot_valid_q || bus.plot_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            code_q        <= '0;
            origin_x_q    <= '0;
            fg_q          <= '0;
            bg_q          <= '0;
            opaque_q      <= 1'b0;
            scale_last    <= '0;
            sx            <= '0;
            sy            <= '0;
            gx            <= '0;
            gy            <= '0;
            cur_x         <= '0;
            cur_y         <= '0;
            last_q        <= 1'b0;
            plot_valid_q  <= 1'b0;
            plot_x_q      <= '0;
            plot_y_q      <= '0;
            plot_colour_q <= '0;
        end else begin
            if (bus.plot_ready)
                plot_valid_q <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        code_q     <= bus.code;
                        origin_x_q <= bus.origin_x;
                        fg_q       <= bus.fg_colour;
                        bg_q       <= bus.bg_colour;
                        opaque_q   <= bus.opaque;
                        scale_last <= scale_eff - 1'b1;
                        sx         <= '0;
                        sy         <= '0;
                        gx         <= '0;
                        gy         <= '0;
                        cur_x      <= bus.origin_x;
                        cur_y      <= bus.origin_y;
                        last_q     <= 1'b0;
                        state      <= S_FETCH;
                    end
                end
                S_FETCH: state <= S_EMIT;
                S_EMIT: begin
                    if (advance) begin
                        if (last_q) begin
                            state <= S_DONE;
                        end else begin
                            if (pixel_lit || opaque_q) begin
                                plot_valid_q  <= 1'b1;
                                plot_x_q      <= cur_x;
                                plot_y_q      <= cur_y;
                                plot_colour_q <= pixel_lit ? fg_q : bg_q;
                            end
                            if (sx != scale_last) begin
                                sx    <= sx + 1'b1;
                                cur_x <= cur_x + 1'b1;
                            end else if (gx != GX_LAST) begin
                                sx    <= '0;
                                gx    <= gx + 1'b1;
                                cur_x <= cur_x + 1'b1;
                            end else begin
                                // Row finished: rewind x, then either refetch or finish.
                                sx    <= '0;
                                gx    <= '0;
                                cur_x <= origin_x_q;
                                if (sy != scale_last) begin
                                    sy    <= sy + 1'b1;
                                    cur_y <= cur_y + 1'b1;
                                    state <= S_FETCH;
                                end else if (gy != GY_LAST) begin
                                    sy    <= '0;
                                    gy    <= gy + 1'b1;
                                    cur_y <= cur_y + 1'b1;
                                    state <= S_FETCH;
                                end else begin
                                    last_q <= 1'b1;
                                end
                            end
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.start_ready = (state == S_IDLE);
    assign bus.done        = (state == S_DONE);
    assign bus.plot_valid  = plot_valid_q;
    assign bus.plot_x      = plot_x_q;
    assign bus.plot_y      = plot_y_q;
    assign bus.plot_colour = plot_colour_q;

endmodule

// File: tb/tb_glyph_blitter.sv
// tb/tb_glyph_blitter.sv - directed self-checking bench for glyph_blitter
module tb_glyph_blitter;
    import glyph_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    glyph_blitter_if bus();

    glyph_blitter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [7:0] px[$];
    logic [7:0] py[$];
    logic [5:0] pc[$];
    logic [7:0] ex[$];
    logic [7:0] ey[$];
    logic [5:0] ec[$];
    int         done_cnt   = 0;
    int         stall_viol = 0;
    bit         rand_ready = 1'b0;

    always @(posedge clk) begin
        #1;
        bus.plot_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    logic       stall_prev = 1'b0;
    logic [7:0] hx, hy;
    logic [5:0] hc;
    always @(negedge clk) begin
        if (!reset) begin
            if (stall_prev && (!bus.plot_valid || bus.plot_x != hx || bus.plot_y != hy || bus.plot_colour != hc))
                stall_viol++;
            if (bus.plot_valid && bus.plot_ready) begin
                px.push_back(bus.plot_x);
                py.push_back(bus.plot_y);
                pc.push_back(bus.plot_colour);
            end
            if (bus.done)
                done_cnt++;
            stall_prev = bus.plot_valid && !bus.plot_ready;
            hx = bus.plot_x;
            hy = bus.plot_y;
            hc = bus.plot_colour;
        end else begin
            stall_prev = 1'b0;
        end
    end

    function automatic logic [7:0] ref_row(input logic [5:0] c, input int r);
        if (c == GLYPH_L)
            return (r == 9) ? 8'b0001_1111 : 8'b0001_0000;
        return 8'h00;
    endfunction

    task automatic build_expected(input logic [5:0] c, input logic [7:0] ox, input logic [7:0] oy,
                                  input logic [5:0] fg, input logic [5:0] bg, input bit opq, input int s);
        logic [7:0] bits;
        logic       lit;
        ex.delete(); ey.delete(); ec.delete();
        for (int gy = 0; gy < 10; gy++) begin
            bits = ref_row(c, gy);
            for (int sy = 0; sy < s; sy++)
                for (int gx = 0; gx < 8; gx++)
                    for (int sx = 0; sx < s; sx++) begin
                        lit = bits[7 - gx];
                        if (lit || opq) begin
                            ex.push_back(8'(int'(ox) + gx * s + sx));
                            ey.push_back(8'(int'(oy) + gy * s + sy));
                            ec.push_back(lit ? fg : bg);
                        end
                    end
        end
    endtask

    task automatic compare_seq(input string tag);
        int mism = 0;
        check({tag, "_count"}, px.size(), ex.size());
        for (int i = 0; i < px.size() && i < ex.size(); i++)
            if (px[i] != ex[i] || py[i] != ey[i] || pc[i] != ec[i])
                mism++;
        check({tag, "_seq"}, mism, 0);
    endtask

    function automatic logic [31:0] pk(input logic [7:0] x, input logic [7:0] y, input logic [5:0] c);
        return {10'd0, x, y, c};
    endfunction

    function automatic logic [31:0] plot_at(input int i);
        if (i < 0 || i >= px.size())
            return 32'hFFFF_FFFF;
        return pk(px[i], py[i], pc[i]);
    endfunction

    task automatic clear_capture();
        px.delete(); py.delete(); pc.delete();
        done_cnt   = 0;
        stall_viol = 0;
    endtask

    task automatic start_glyph(input logic [5:0] c, input logic [7:0] ox, input logic [7:0] oy,
                               input logic [5:0] fg, input logic [5:0] bg, input bit opq, input logic [2:0] s);
        @(posedge clk); #1;
        bus.code      = c;
        bus.origin_x  = ox;
        bus.origin_y  = oy;
        bus.fg_colour = fg;
        bus.bg_colour = bg;
        bus.opaque    = opq;
        bus.scale     = s;
        bus.start     = 1'b1;
        @(posedge clk); #1;
        bus.start     = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        check({tag, "_done_seen"}, 32'(done_cnt > 0), 1);
        repeat (4) @(posedge clk);
        #1;
        check({tag, "_done_once"}, done_cnt, 1);
        check({tag, "_ready_back"}, 32'(bus.start_ready), 1);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start     = 1'b0;
        bus.code      = '0;
        bus.origin_x  = '0;
        bus.origin_y  = '0;
        bus.fg_colour = '0;
        bus.bg_colour = '0;
        bus.opaque    = 1'b0;
        bus.scale     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_start_ready", 32'(bus.start_ready), 1);
        check("rst_plot_valid",  32'(bus.plot_valid), 0);
        check("rst_plot_xyc",    pk(bus.plot_x, bus.plot_y, bus.plot_colour), 0);
        check("rst_done",        32'(bus.done), 0);
        reset = 1'b0;

        // Transparent, scale 1
        clear_capture();
        build_expected(GLYPH_L, 8'd10, 8'd20, 6'h2A, 6'h05, 1'b0, 1);
        start_glyph(GLYPH_L, 8'd10, 8'd20, 6'h2A, 6'h05, 1'b0, 3'd1);
        wait_done("t1", 2000);
        compare_seq("t1");
        check("t1_first", plot_at(0), pk(8'd13, 8'd20, 6'h2A));
        check("t1_last",  plot_at(13), pk(8'd17, 8'd29, 6'h2A));

        // Opaque, scale 1
        clear_capture();
        build_expected(GLYPH_L, 8'd10, 8'd20, 6'h3F, 6'h00, 1'b1, 1);
        start_glyph(GLYPH_L, 8'd10, 8'd20, 6'h3F, 6'h00, 1'b1, 3'd1);
        wait_done("t2", 2000);
        compare_seq("t2");
        check("t2_p0_bg",  plot_at(0),  pk(8'd10, 8'd20, 6'h00));
        check("t2_p3_fg",  plot_at(3),  pk(8'd13, 8'd20, 6'h3F));
        check("t2_last",   plot_at(79), pk(8'd17, 8'd29, 6'h3F));

        // Opaque, scale 2
        clear_capture();
        build_expected(GLYPH_L, 8'd0, 8'd0, 6'h3F, 6'h00, 1'b1, 2);
        start_glyph(GLYPH_L, 8'd0, 8'd0, 6'h3F, 6'h00, 1'b1, 3'd2);
        wait_done("t3", 4000);
        compare_seq("t3");
        check("t3_6_0",  plot_at(6),   pk(8'd6, 8'd0, 6'h3F));
        check("t3_7_0",  plot_at(7),   pk(8'd7, 8'd0, 6'h3F));
        check("t3_6_1",  plot_at(22),  pk(8'd6, 8'd1, 6'h3F));
        check("t3_7_1",  plot_at(23),  pk(8'd7, 8'd1, 6'h3F));
        check("t3_8_0",  plot_at(8),   pk(8'd8, 8'd0, 6'h00));
        check("t3_last", plot_at(319), pk(8'd15, 8'd19, 6'h3F));

        // X wrap at the right edge
        clear_capture();
        build_expected(GLYPH_L, 8'd252, 8'd0, 6'h11, 6'h00, 1'b0, 1);
        start_glyph(GLYPH_L, 8'd252, 8'd0, 6'h11, 6'h00, 1'b0, 3'd1);
        wait_done("t4", 2000);
        compare_seq("t4");
        check("t4_x255", plot_at(9),  pk(8'd255, 8'd9, 6'h11));
        check("t4_x0",   plot_at(10), pk(8'd0,   8'd9, 6'h11));
        check("t4_x1",   plot_at(11), pk(8'd1,   8'd9, 6'h11));
        check("t4_x2",   plot_at(12), pk(8'd2,   8'd9, 6'h11));
        check("t4_x3",   plot_at(13), pk(8'd3,   8'd9, 6'h11));

        // Back-pressure plus a start while busy
        clear_capture();
        rand_ready = 1'b1;
        build_expected(GLYPH_L, 8'd40, 8'd50, 6'h15, 6'h00, 1'b0, 1);
        start_glyph(GLYPH_L, 8'd40, 8'd50, 6'h15, 6'h00, 1'b0, 3'd1);
        repeat (12) @(posedge clk);
        start_glyph(GLYPH_T, 8'd0, 8'd0, 6'h01, 6'h02, 1'b1, 3'd3);
        wait_done("t5", 4000);
        rand_ready = 1'b0;
        compare_seq("t5");
        check("t5_stall_stable", stall_viol, 0);

        // Reset after the fifth plot
        clear_capture();
        start_glyph(GLYPH_L, 8'd10, 8'd20, 6'h2A, 6'h00, 1'b0, 3'd1);
        for (int n = 0; px.size() < 5 && n < 500; n++)
            @(posedge clk);
        check("t6_reached_5", 32'(px.size() >= 5), 1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("t6_valid_dropped", 32'(bus.plot_valid), 0);
        check("t6_start_ready",   32'(bus.start_ready), 1);
        repeat (30) @(posedge clk);
        check("t6_no_done", done_cnt, 0);
        clear_capture();
        build_expected(GLYPH_L, 8'd10, 8'd20, 6'h2A, 6'h00, 1'b0, 1);
        start_glyph(GLYPH_L, 8'd10, 8'd20, 6'h2A, 6'h00, 1'b0, 3'd1);
        wait_done("t6b", 2000);
        compare_seq("t6b");

        // Blank code in transparent mode: no plots, done still pulses
        clear_capture();
        start_glyph(6'd63, 8'd5, 8'd5, 6'h3F, 6'h01, 1'b0, 3'd1);
        wait_done("t7", 2000);
        check("t7_no_plots", px.size(), 0);

        // Scale 0 behaves as 1, scale 7 saturates to 4
        clear_capture();
        build_expected(GLYPH_L, 8'd30, 8'd30, 6'h07, 6'h00, 1'b0, 1);
        start_glyph(GLYPH_L, 8'd30, 8'd30, 6'h07, 6'h00, 1'b0, 3'd0);
        wait_done("t8", 2000);
        compare_seq("t8");

        clear_capture();
        build_expected(GLYPH_L, 8'd30, 8'd30, 6'h07, 6'h00, 1'b0, 4);
        start_glyph(GLYPH_L, 8'd30, 8'd30, 6'h07, 6'h00, 1'b0, 3'd7);
        wait_done("t9", 6000);
        compare_seq("t9");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
